// File: rtl/branch_recovery_unit.sv
// Branch recovery unit: tracks in-flight branches, detects mispredictions at resolve
// and issues a single-cycle flush/redirect followed by a short dispatch stall.
module branch_recovery_unit #(
    parameter int NUM_BR         = 4,
    parameter int ROB_DEPTH      = 16,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alloc_valid,
    input  logic [4:0]  alloc_rob_index,
    input  logic        alloc_pred_taken,
    input  logic [31:0] alloc_pred_target,
    input  logic [31:0] alloc_fallthrough,
    output logic        br_full,
    input  logic        res_valid,
    input  logic [4:0]  res_rob_index,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic [4:0]  rob_head,
    output logic        flush,
    output logic [4:0]  flush_tag,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        stall
);

    localparam int IW = (NUM_BR > 1) ? $clog2(NUM_BR) : 1;
    localparam int CW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, FLUSH, RECOVER} state_t;

    logic [NUM_BR-1:0] valid_q, valid_d;
    logic [4:0]        tag_q   [NUM_BR];
    logic              ptk_q   [NUM_BR];
    logic [31:0]       ptgt_q  [NUM_BR];
    logic [31:0]       ft_q    [NUM_BR];

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              flush_q, flush_d;
    logic [4:0]        flush_tag_q, flush_tag_d;
    logic [31:0]       redirect_pc_q, redirect_pc_d;
    logic              stall_q, stall_d;
    logic              pend_q, pend_d;
    logic [4:0]        pend_tag_q, pend_tag_d;
    logic [31:0]       pend_pc_q, pend_pc_d;

    logic              res_hit, alloc_dup, free_found;
    logic [IW-1:0]     res_idx, free_idx;
    logic              alloc_ok, res_ok, res_mis;
    logic [31:0]       res_pc;
    logic [5:0]        res_age, flush_age, pend_age;

    // Distance from the ROB head; larger means younger.
    function automatic logic [5:0] age_of(input logic [4:0] t, input logic [4:0] h);
        logic [5:0] d;
        d = {1'b0, t} - {1'b0, h};
        if (t < h) d = d + 6'(ROB_DEPTH);
        return d;
    endfunction

    always_comb begin
        res_hit    = 1'b0;
        res_idx    = '0;
        alloc_dup  = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        // Descending scan so the lowest free slot wins.
        for (int i = NUM_BR - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == res_rob_index) begin
                res_hit = 1'b1;
                res_idx = IW'(i);
            end
            if (valid_q[i] && tag_q[i] == alloc_rob_index) alloc_dup = 1'b1;
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    assign br_full   = &valid_q;
    assign res_age   = age_of(res_rob_index, rob_head);
    assign flush_age = age_of(flush_tag_q, rob_head);
    assign pend_age  = age_of(pend_tag_q, rob_head);
    assign alloc_ok  = alloc_valid && free_found && !stall_q && !alloc_dup;
    assign res_ok    = res_valid && res_hit
                    && !(alloc_valid && alloc_rob_index == res_rob_index)
                    && (state_q != FLUSH || res_age < flush_age);
    assign res_mis   = (res_taken != ptk_q[res_idx])
                    || (res_taken && res_target != ptgt_q[res_idx]);
    assign res_pc    = res_taken ? res_target : ft_q[res_idx];

    always_comb begin
        valid_d       = valid_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        flush_d       = 1'b0;
        flush_tag_d   = flush_tag_q;
        redirect_pc_d = redirect_pc_q;
        pend_d        = 1'b0;
        pend_tag_d    = pend_tag_q;
        pend_pc_d     = pend_pc_q;

        if (state_q == FLUSH) begin
            for (int i = 0; i < NUM_BR; i++) begin
                if (valid_q[i] && age_of(tag_q[i], rob_head) >= flush_age) valid_d[i] = 1'b0;
            end
        end
        if (res_ok && !res_mis) valid_d[res_idx] = 1'b0;
        if (alloc_ok) valid_d[free_idx] = 1'b1;

        case (state_q)
            IDLE: begin
                if (res_ok && res_mis) begin
                    state_d       = FLUSH;
                    flush_d       = 1'b1;
                    flush_tag_d   = res_rob_index;
                    redirect_pc_d = res_pc;
                end
            end
            FLUSH: begin
                state_d = RECOVER;
                cnt_d   = CW'(RECOVER_CYCLES - 1);
                // An older mispredict here is held one cycle so flush never pulses back to back.
                if (res_ok && res_mis) begin
                    pend_d     = 1'b1;
                    pend_tag_d = res_rob_index;
                    pend_pc_d  = res_pc;
                end
            end
            RECOVER: begin
                if (res_ok && res_mis && (!pend_q || res_age < pend_age)) begin
                    state_d       = FLUSH;
                    flush_d       = 1'b1;
                    flush_tag_d   = res_rob_index;
                    redirect_pc_d = res_pc;
                end else if (pend_q) begin
                    state_d       = FLUSH;
                    flush_d       = 1'b1;
                    flush_tag_d   = pend_tag_q;
                    redirect_pc_d = pend_pc_q;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        stall_d = (state_d != IDLE);
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q       <= '0;
            state_q       <= IDLE;
            cnt_q         <= '0;
            flush_q       <= 1'b0;
            flush_tag_q   <= '0;
            redirect_pc_q <= '0;
            stall_q       <= 1'b0;
            pend_q        <= 1'b0;
            pend_tag_q    <= '0;
            pend_pc_q     <= '0;
        end else begin
            valid_q       <= valid_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            flush_q       <= flush_d;
            flush_tag_q   <= flush_tag_d;
            redirect_pc_q <= redirect_pc_d;
            stall_q       <= stall_d;
            pend_q        <= pend_d;
            pend_tag_q    <= pend_tag_d;
            pend_pc_q     <= pend_pc_d;
        end
    end

    // NOTE: entry payload is not reset; it is only ever read behind a set valid bit.
    always_ff @(posedge clk) begin
        if (alloc_ok) begin
            tag_q[free_idx]  <= alloc_rob_index;
            ptk_q[free_idx]  <= alloc_pred_taken;
            ptgt_q[free_idx] <= alloc_pred_target;
            ft_q[free_idx]   <= alloc_fallthrough;
        end
    end

    assign flush          = flush_q;
    assign flush_tag      = flush_tag_q;
    assign redirect_valid = flush_q;
    assign redirect_pc    = redirect_pc_q;
    assign stall          = stall_q;

endmodule
